imem_boot_loader: RTL and testbench

- Boot sequencer for the single-cycle RISC-V core.
- Holds the core in reset and accepts a byte stream over a valid/ready handshake, assembling it into 32-bit words.
- Writes the words sequentially into instruction memory from word address 0, then releases the core reset.
- Replaces file preloading of instruction memory with a hardware load path. Sits between the host/UART byte source, the instruction memory write port and the core reset input.

---
 rtl/imem_boot_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed byte stream and assembles it into
// little-endian 32-bit words. Each word is written to instruction memory,
// starting at word address 0. The core is held in reset until the last
// word has been written.
module imem_boot_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              overflow,
   output logic [15:0]       words_loaded
);

   localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_DRAIN,
      S_RUN
   } state_t;

   state_t state_q, state_d;

   logic [15:0]       n_q, n_d;
   logic [1:0]        idx_q, idx_d;
   logic [23:0]       asm_q, asm_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              core_rst_q, core_rst_d;
   logic              done_q, done_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       words_q, words_d;

   logic accept;
   logic last_word;

   assign accept    = in_valid && in_ready;
   assign last_word = (({1'b0, words_q} + 17'd1) == {1'b0, n_q});

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_LEN_LO;
      else     state_q <= state_d;
   end

   // Next-state decode; reload overrides any byte accepted on the same edge
   always_comb begin
      state_d = state_q;
      if (reload) begin
         state_d = S_LEN_LO;
      end else begin
         case (state_q)
            S_LEN_LO: if (accept) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) state_d = ({in_data, n_q[7:0]} == 16'd0) ? S_DRAIN : S_DATA;
            S_DATA:   if (accept && (idx_q == 2'd3) && last_word) state_d = S_DRAIN;
            S_DRAIN:  state_d = S_RUN;
            S_RUN:    state_d = S_RUN;
            default:  state_d = S_LEN_LO;
         endcase
      end
   end

   // Output and datapath next values; in_ready is decoded directly from state
   always_comb begin
      in_ready    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
      n_d         = n_q;
      idx_d       = idx_q;
      asm_d       = asm_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      core_rst_d  = core_rst_q;
      done_d      = done_q;
      overflow_d  = overflow_q;
      words_d     = words_q;
      if (reload) begin
         core_rst_d = 1'b1;
         done_d     = 1'b0;
         overflow_d = 1'b0;
         words_d    = '0;
         idx_d      = '0;
      end else begin
         case (state_q)
            S_LEN_LO: if (accept) n_d[7:0] = in_data;
            S_LEN_HI: begin
               if (accept) begin
                  n_d[15:8] = in_data;
                  if ({17'd0, in_data, n_q[7:0]} > DEPTH) overflow_d = 1'b1;
               end
            end
            S_DATA: begin
               if (accept) begin
                  // bytes shift in from the top so byte 0 ends up in [7:0]
                  asm_d = {in_data, asm_q[23:8]};
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     if ({17'd0, words_q} < DEPTH) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = words_q[ADDR_W-1:0];
                        mem_wdata_d = {in_data, asm_q};
                     end
                     words_d = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
                  end
               end
            end
            S_DRAIN: begin
               core_rst_d = 1'b0;
               done_d     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q         <= '0;
         idx_q       <= '0;
         asm_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         core_rst_q  <= 1'b1;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         words_q     <= '0;
      end else begin
         n_q         <= n_d;
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         core_rst_q  <= core_rst_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
         words_q     <= words_d;
      end
   end

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign core_rst     = core_rst_q;
   assign done         = done_q;
   assign overflow     = overflow_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: instance A uses the default
// ADDR_W=8, instance B uses ADDR_W=2 for the capacity-overflow case.
module tb_imem_boot_loader;

   logic clk = 1'b0;
   logic rst;

   logic [7:0]  a_data;
   logic        a_valid, a_ready, a_reload, a_we, a_core_rst, a_done, a_ovf;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [15:0] a_words;

   logic [7:0]  b_data;
   logic        b_valid, b_ready, b_reload, b_we, b_core_rst, b_done, b_ovf;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [15:0] b_words;

   int total = 0;
   int bad   = 0;

   logic [7:0]  s1 [0:9];
   logic [7:0]  la_addr [$];
   logic [31:0] la_data [$];
   logic [1:0]  lb_addr [$];
   logic [31:0] lb_data [$];

   always #5 clk = ~clk;

   imem_boot_loader #(.ADDR_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
      .reload(a_reload), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .core_rst(a_core_rst), .done(a_done), .overflow(a_ovf), .words_loaded(a_words)
   );

   imem_boot_loader #(.ADDR_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .reload(b_reload), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .core_rst(b_core_rst), .done(b_done), .overflow(b_ovf), .words_loaded(b_words)
   );

   // Record every memory write seen by each instance
   always @(negedge clk) begin
      if (a_we) begin la_addr.push_back(a_addr); la_data.push_back(a_wdata); end
      if (b_we) begin lb_addr.push_back(b_addr); lb_data.push_back(b_wdata); end
   end

   task automatic do_rst;
      @(negedge clk);
      rst = 1'b1; a_valid = 1'b0; a_reload = 1'b0; b_valid = 1'b0; b_reload = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      la_addr.delete(); la_data.delete(); lb_addr.delete(); lb_data.delete();
   endtask

   task automatic put_a(input logic [7:0] b);
      @(negedge clk);
      a_data = b; a_valid = 1'b1;
   endtask

   task automatic put_b(input logic [7:0] b);
      @(negedge clk);
      b_data = b; b_valid = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      total++; if (a_core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst got=%0b exp=1", a_core_rst); end
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", a_ready); end
      total++; if ({a_we, a_done, a_ovf} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {a_we, a_done, a_ovf}); end
      total++; if ({a_addr, a_wdata, a_words} !== 56'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {a_addr, a_wdata, a_words}); end
      do_rst();
   endtask

   task automatic test_basic;
      do_rst();
      for (int i = 0; i < 10; i++) put_a(s1[i]);
      @(posedge clk); #1;
      a_valid = 1'b0;
      total++; if (a_we !== 1'b1) begin bad++; $display("FAIL basic_last_we got=%0b exp=1", a_we); end
      total++; if (a_addr !== 8'd1) begin bad++; $display("FAIL basic_last_addr got=%0d exp=1", a_addr); end
      total++; if (a_wdata !== 32'h00200593) begin bad++; $display("FAIL basic_last_data got=%h exp=00200593", a_wdata); end
      total++; if ({a_core_rst, a_done, a_ready} !== 3'b100) begin bad++; $display("FAIL basic_drain got=%b exp=100", {a_core_rst, a_done, a_ready}); end
      @(posedge clk); #1;
      total++; if ({a_core_rst, a_done, a_ready, a_we} !== 4'b0100) begin bad++; $display("FAIL basic_run got=%b exp=0100", {a_core_rst, a_done, a_ready, a_we}); end
      total++; if (a_words !== 16'd2) begin bad++; $display("FAIL basic_words got=%0d exp=2", a_words); end
      total++; if (la_addr.size() !== 2) begin bad++; $display("FAIL basic_nwrites got=%0d exp=2", la_addr.size()); end
      else begin
         total++; if ({la_addr[0], la_data[0]} !== {8'd0, 32'h00100513}) begin bad++; $display("FAIL basic_w0 got=%0d/%h exp=0/00100513", la_addr[0], la_data[0]); end
         total++; if ({la_addr[1], la_data[1]} !== {8'd1, 32'h00200593}) begin bad++; $display("FAIL basic_w1 got=%0d/%h exp=1/00200593", la_addr[1], la_data[1]); end
      end
      @(posedge clk); #1;
      total++; if ({a_core_rst, a_done, a_ready} !== 3'b010) begin bad++; $display("FAIL basic_run_hold got=%b exp=010", {a_core_rst, a_done, a_ready}); end
   endtask

   task automatic test_zero_header;
      do_rst();
      put_a(8'h00); put_a(8'h00);
      @(posedge clk); #1;
      a_valid = 1'b0;
      total++; if ({a_core_rst, a_done, a_ready} !== 3'b100) begin bad++; $display("FAIL zero_drain got=%b exp=100", {a_core_rst, a_done, a_ready}); end
      @(posedge clk); #1;
      total++; if ({a_core_rst, a_done} !== 2'b01) begin bad++; $display("FAIL zero_run got=%b exp=01", {a_core_rst, a_done}); end
      total++; if (la_addr.size() !== 0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", la_addr.size()); end
   endtask

   task automatic test_gaps;
      logic       exp_we;
      logic [15:0] exp_w;
      do_rst();
      for (int i = 0; i < 10; i++) begin
         put_a(s1[i]);
         @(negedge clk);
         exp_we = (i == 5) || (i == 9);
         exp_w  = (i < 5) ? 16'd0 : (i < 9) ? 16'd1 : 16'd2;
         total++; if (a_we !== exp_we) begin bad++; $display("FAIL gaps_we byte=%0d got=%0b exp=%0b", i, a_we, exp_we); end
         total++; if (a_words !== exp_w) begin bad++; $display("FAIL gaps_words byte=%0d got=%0d exp=%0d", i, a_words, exp_w); end
         a_valid = 1'b0;
      end
      @(posedge clk); #1;
      total++; if ({a_core_rst, a_done} !== 2'b01) begin bad++; $display("FAIL gaps_run got=%b exp=01", {a_core_rst, a_done}); end
      total++; if (la_addr.size() !== 2) begin bad++; $display("FAIL gaps_nwrites got=%0d exp=2", la_addr.size()); end
      else begin
         total++; if ({la_addr[0], la_data[0]} !== {8'd0, 32'h00100513}) begin bad++; $display("FAIL gaps_w0 got=%0d/%h exp=0/00100513", la_addr[0], la_data[0]); end
         total++; if ({la_addr[1], la_data[1]} !== {8'd1, 32'h00200593}) begin bad++; $display("FAIL gaps_w1 got=%0d/%h exp=1/00200593", la_addr[1], la_data[1]); end
      end
   endtask

   task automatic test_overflow;
      do_rst();
      put_b(8'h05);
      @(posedge clk); #1;
      total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", b_ovf); end
      put_b(8'h00);
      @(posedge clk); #1;
      total++; if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_after_header got=%0b exp=1", b_ovf); end
      for (int k = 0; k < 5; k++)
         for (int j = 0; j < 4; j++) put_b(8'(k * 16 + j));
      @(posedge clk); #1;
      b_valid = 1'b0;
      total++; if (b_we !== 1'b0) begin bad++; $display("FAIL ovf_discard_we got=%0b exp=0", b_we); end
      total++; if (b_words !== 16'd5) begin bad++; $display("FAIL ovf_words got=%0d exp=5", b_words); end
      @(posedge clk); #1;
      total++; if ({b_done, b_ovf, b_core_rst} !== 3'b110) begin bad++; $display("FAIL ovf_end got=%b exp=110", {b_done, b_ovf, b_core_rst}); end
      total++; if (lb_addr.size() !== 4) begin bad++; $display("FAIL ovf_nwrites got=%0d exp=4", lb_addr.size()); end
      else begin
         total++; if ({lb_addr[0], lb_data[0]} !== {2'd0, 32'h03020100}) begin bad++; $display("FAIL ovf_w0 got=%0d/%h exp=0/03020100", lb_addr[0], lb_data[0]); end
         total++; if ({lb_addr[3], lb_data[3]} !== {2'd3, 32'h33323130}) begin bad++; $display("FAIL ovf_w3 got=%0d/%h exp=3/33323130", lb_addr[3], lb_data[3]); end
      end
      @(negedge clk); b_reload = 1'b1;
      @(negedge clk); b_reload = 1'b0;
      total++; if ({b_ovf, b_done, b_core_rst, b_ready} !== 4'b0011) begin bad++; $display("FAIL ovf_reload got=%b exp=0011", {b_ovf, b_done, b_core_rst, b_ready}); end
   endtask

   task automatic test_reload;
      do_rst();
      for (int i = 0; i < 8; i++) put_a(s1[i]);
      // reload with a byte offered on the same edge: the byte must be dropped
      @(negedge clk);
      a_reload = 1'b1; a_valid = 1'b1; a_data = 8'hAA;
      @(negedge clk);
      a_reload = 1'b0; a_valid = 1'b0;
      total++; if ({a_ready, a_core_rst, a_done, a_we} !== 4'b1100) begin bad++; $display("FAIL reload_state got=%b exp=1100", {a_ready, a_core_rst, a_done, a_we}); end
      total++; if (a_words !== 16'd0) begin bad++; $display("FAIL reload_words got=%0d exp=0", a_words); end
      put_a(8'h01); put_a(8'h00);
      put_a(8'hEF); put_a(8'hBE); put_a(8'hAD); put_a(8'hDE);
      @(posedge clk); #1;
      a_valid = 1'b0;
      total++; if ({a_we, a_addr, a_wdata} !== {1'b1, 8'd0, 32'hDEADBEEF}) begin bad++; $display("FAIL reload_write got=%0b/%0d/%h exp=1/0/deadbeef", a_we, a_addr, a_wdata); end
      @(posedge clk); #1;
      total++; if ({a_done, a_core_rst, a_words} !== {2'b10, 16'd1}) begin bad++; $display("FAIL reload_end got=%0b/%0b/%0d exp=1/0/1", a_done, a_core_rst, a_words); end
      total++; if (la_addr.size() !== 2) begin bad++; $display("FAIL reload_nwrites got=%0d exp=2", la_addr.size()); end
      else begin
         total++; if ({la_addr[0], la_data[0]} !== {8'd0, 32'h00100513}) begin bad++; $display("FAIL reload_w0 got=%0d/%h exp=0/00100513", la_addr[0], la_data[0]); end
         total++; if ({la_addr[1], la_data[1]} !== {8'd0, 32'hDEADBEEF}) begin bad++; $display("FAIL reload_w1 got=%0d/%h exp=0/deadbeef", la_addr[1], la_data[1]); end
      end
   endtask

   task automatic test_async_reset;
      do_rst();
      for (int i = 0; i < 6; i++) put_a(s1[i]);
      @(negedge clk);
      a_valid = 1'b0;
      total++; if ({a_we, a_wdata} !== {1'b1, 32'h00100513}) begin bad++; $display("FAIL arst_pre got=%0b/%h exp=1/00100513", a_we, a_wdata); end
      #2 rst = 1'b1;
      #1;
      total++; if ({a_we, a_done, a_ovf, a_core_rst, a_ready} !== 5'b00011) begin bad++; $display("FAIL arst_flags got=%b exp=00011", {a_we, a_done, a_ovf, a_core_rst, a_ready}); end
      total++; if ({a_addr, a_wdata, a_words} !== 56'd0) begin bad++; $display("FAIL arst_regs got=%h exp=0", {a_addr, a_wdata, a_words}); end
      do_rst();
      for (int i = 0; i < 10; i++) put_a(s1[i]);
      @(posedge clk); #1;
      a_valid = 1'b0;
      @(posedge clk); #1;
      total++; if ({a_done, a_core_rst, a_words} !== {2'b10, 16'd2}) begin bad++; $display("FAIL arst_reload_end got=%0b/%0b/%0d exp=1/0/2", a_done, a_core_rst, a_words); end
      total++; if (la_addr.size() !== 2) begin bad++; $display("FAIL arst_nwrites got=%0d exp=2", la_addr.size()); end
      else begin
         total++; if ({la_addr[1], la_data[1]} !== {8'd1, 32'h00200593}) begin bad++; $display("FAIL arst_w1 got=%0d/%h exp=1/00200593", la_addr[1], la_data[1]); end
      end
   endtask

   initial begin
      rst = 1'b1;
      a_data = '0; a_valid = 1'b0; a_reload = 1'b0;
      b_data = '0; b_valid = 1'b0; b_reload = 1'b0;
      s1[0] = 8'h02; s1[1] = 8'h00;
      s1[2] = 8'h13; s1[3] = 8'h05; s1[4] = 8'h10; s1[5] = 8'h00;
      s1[6] = 8'h93; s1[7] = 8'h05; s1[8] = 8'h20; s1[9] = 8'h00;
      test_reset();
      test_basic();
      test_zero_header();
      test_gaps();
      test_overflow();
      test_reload();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
